exe_stage: RTL and testbench



---
 rtl/exe_stage_pkg.sv | 29 ++
 rtl/exe_alu.sv | 31 +++
 rtl/exe_stage.sv | 94 +++++++++
 tb/tb_exe_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared encodings for the execute stage: ALU command codes, branch types,
// memory-control bit positions and datapath width.
package exe_stage_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_W      = 5;
   localparam int MEM_RD_BIT = 1;
   localparam int MEM_WR_BIT = 0;

   typedef enum logic [3:0] {
      CMD_ADD = 4'b0000,
      CMD_SUB = 4'b0010,
      CMD_AND = 4'b0100,
      CMD_OR  = 4'b0101,
      CMD_NOR = 4'b0110,
      CMD_XOR = 4'b0111,
      CMD_SLL = 4'b1000,
      CMD_SRA = 4'b1001,
      CMD_SRL = 4'b1010
   } exe_cmd_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_BEZ  = 2'b01,
      BR_BNE  = 2'b10,
      BR_JMP  = 2'b11
   } br_type_e;

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU for the execute stage; unlisted command codes produce 0.
module exe_alu
   import exe_stage_pkg::*;
(
   input  logic [DATA_W-1:0] val1_i,
   input  logic [DATA_W-1:0] val2_i,
   input  logic [3:0]        exe_cmd_i,
   output logic [DATA_W-1:0] result_o
);

   logic [4:0] shamt;

   assign shamt = val2_i[4:0];

   always_comb begin
      result_o = '0;
      case (exe_cmd_i)
         CMD_ADD: result_o = val1_i + val2_i;
         CMD_SUB: result_o = val1_i - val2_i;
         CMD_AND: result_o = val1_i & val2_i;
         CMD_OR:  result_o = val1_i | val2_i;
         CMD_NOR: result_o = ~(val1_i | val2_i);
         CMD_XOR: result_o = val1_i ^ val2_i;
         CMD_SLL: result_o = val1_i << shamt;
         CMD_SRA: result_o = $unsigned($signed(val1_i) >>> shamt);
         CMD_SRL: result_o = val1_i >> shamt;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, branch resolution with IF redirect / younger-instruction
// squash, and the EXE/MEM pipeline register.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val2,
   input  logic [DATA_W-1:0] reg2,
   input  logic [DATA_W-1:0] PCIn,
   input  logic [3:0]        EXE_CMD,
   input  logic [1:0]        MEM_SignalIn,
   input  logic [1:0]        Branch_Type,
   input  logic              WB_ENin,
   input  logic [REG_W-1:0]  destIn,
   input  logic              flushIn,
   input  logic              freeze,
   output logic              Br_taken,
   output logic [DATA_W-1:0] Br_addr,
   output logic              flushOut,
   output logic [DATA_W-1:0] ALU_resOut,
   output logic [DATA_W-1:0] ST_valOut,
   output logic [REG_W-1:0]  destOut,
   output logic [1:0]        MEM_SignalOut,
   output logic              WB_ENout
);

   logic [DATA_W-1:0] alu_res;
   logic              br_cond;

   logic [DATA_W-1:0] alu_res_d, alu_res_q;
   logic [DATA_W-1:0] st_val_d,  st_val_q;
   logic [REG_W-1:0]  dest_d,    dest_q;
   logic [1:0]        mem_sig_d, mem_sig_q;
   logic              wb_en_d,   wb_en_q;

   exe_alu u_alu (
      .val1_i    (val1),
      .val2_i    (val2),
      .exe_cmd_i (EXE_CMD),
      .result_o  (alu_res)
   );

   always_comb begin
      br_cond = 1'b0;
      case (Branch_Type)
         BR_BEZ:  br_cond = (val1 == '0);
         BR_BNE:  br_cond = (val1 != reg2);
         BR_JMP:  br_cond = 1'b1;
         default: br_cond = 1'b0;
      endcase
   end

   // Target is word-offset relative to PC+4 and is driven even when not taken.
   assign Br_addr  = PCIn + {val2[DATA_W-3:0], 2'b00};
   // A squashed or frozen branch must not redirect; a frozen one re-resolves later.
   assign Br_taken = br_cond & ~flushIn & ~freeze & ~rst;
   assign flushOut = Br_taken;

   // Bubbles only need their side-effect enables cleared.
   always_comb begin
      alu_res_d             = alu_res;
      st_val_d              = reg2;
      dest_d                = destIn;
      wb_en_d               = WB_ENin & ~flushIn;
      mem_sig_d             = 2'b00;
      mem_sig_d[MEM_RD_BIT] = MEM_SignalIn[MEM_RD_BIT] & ~flushIn;
      mem_sig_d[MEM_WR_BIT] = MEM_SignalIn[MEM_WR_BIT] & ~flushIn;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_res_q <= '0;
         st_val_q  <= '0;
         dest_q    <= '0;
         mem_sig_q <= 2'b00;
         wb_en_q   <= 1'b0;
      end else if (!freeze) begin
         alu_res_q <= alu_res_d;
         st_val_q  <= st_val_d;
         dest_q    <= dest_d;
         mem_sig_q <= mem_sig_d;
         wb_en_q   <= wb_en_d;
      end
   end

   assign ALU_resOut    = alu_res_q;
   assign ST_valOut     = st_val_q;
   assign destOut       = dest_q;
   assign MEM_SignalOut = mem_sig_q;
   assign WB_ENout      = wb_en_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized streams
// against an arithmetic reference model of the ALU, branch and stage register.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] val1, val2, reg2, PCIn;
   logic [3:0]  EXE_CMD;
   logic [1:0]  MEM_SignalIn, Branch_Type;
   logic        WB_ENin, flushIn, freeze;
   logic [4:0]  destIn;
   logic        Br_taken, flushOut, WB_ENout;
   logic [31:0] Br_addr, ALU_resOut, ST_valOut;
   logic [4:0]  destOut;
   logic [1:0]  MEM_SignalOut;

   int vectors = 0;
   int miscompares = 0;

   exe_stage dut (
      .clk(clk), .rst(rst), .val1(val1), .val2(val2), .reg2(reg2), .PCIn(PCIn),
      .EXE_CMD(EXE_CMD), .MEM_SignalIn(MEM_SignalIn), .Branch_Type(Branch_Type),
      .WB_ENin(WB_ENin), .destIn(destIn), .flushIn(flushIn), .freeze(freeze),
      .Br_taken(Br_taken), .Br_addr(Br_addr), .flushOut(flushOut),
      .ALU_resOut(ALU_resOut), .ST_valOut(ST_valOut), .destOut(destOut),
      .MEM_SignalOut(MEM_SignalOut), .WB_ENout(WB_ENout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
      int unsigned s;
      logic [31:0] ones;
      s = b % 32;
      ones = 32'hFFFF_FFFF;
      case (cmd)
         4'd0:    return a + b;
         4'd2:    return a - b;
         4'd4:    return a & b;
         4'd5:    return a | b;
         4'd6:    return ~(a | b);
         4'd7:    return a ^ b;
         4'd8:    return a << s;
         4'd9:    return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
         4'd10:   return a >> s;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic br_ref(input logic [1:0] bt, input logic [31:0] a, input logic [31:0] r);
      case (bt)
         2'd1:    return a == 32'd0;
         2'd2:    return a != r;
         2'd3:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [31:0] pc, input logic [1:0] mem,
                        input logic [1:0] bt, input logic wb, input logic [4:0] dest,
                        input logic fl, input logic fz);
      EXE_CMD = cmd; val1 = a; val2 = b; reg2 = r; PCIn = pc; MEM_SignalIn = mem;
      Branch_Type = bt; WB_ENin = wb; destIn = dest; flushIn = fl; freeze = fz;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(4'd0, 32'd1, 32'd2, 32'd3, 32'd4, 2'b11, 2'd3, 1'b1, 5'd9, 1'b0, 1'b0);
      tick();
      vectors++;
      if ({ALU_resOut, ST_valOut, destOut, MEM_SignalOut, WB_ENout} !== 72'd0) begin
         miscompares++;
         $display("FAIL reset_regs got res=%h st=%h dest=%0d mem=%b wb=%b want all 0",
                  ALU_resOut, ST_valOut, destOut, MEM_SignalOut, WB_ENout);
      end
      vectors++;
      if (Br_taken !== 1'b0 || flushOut !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_br got taken=%b flush=%b want 0 0", Br_taken, flushOut);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu_directed();
      logic [3:0]  cmd [10] = '{4'd0, 4'd2, 4'd9, 4'd10, 4'd6, 4'd8, 4'd9, 4'd8, 4'd1, 4'd7};
      logic [31:0] a   [10] = '{32'd5, 32'd3, 32'h8000_0000, 32'h8000_0000, 32'd0,
                                32'd1, 32'h8765_4321, 32'd1, 32'hFFFF_FFFF, 32'hF0F0_F0F0};
      logic [31:0] b   [10] = '{32'd7, 32'd5, 32'd4, 32'd4, 32'd0,
                                32'd31, 32'd0, 32'd35, 32'hFFFF_FFFF, 32'hFF00_FF00};
      logic [31:0] exp [10] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000, 32'h0800_0000,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'h8765_4321, 32'd8,
                                32'd0, 32'h0FF0_0FF0};
      drive(cmd[0], a[0], b[0], 32'd0, 32'd0, 2'b00, 2'd0, 1'b1, 5'd3, 1'b0, 1'b0);
      tick();
      vectors++;
      if (ALU_resOut !== 32'd12 || WB_ENout !== 1'b1 || destOut !== 5'd3) begin
         miscompares++;
         $display("FAIL add_wb got res=%0d wb=%b dest=%0d want 12 1 3", ALU_resOut, WB_ENout, destOut);
      end
      for (int i = 1; i < 10; i++) begin
         drive(cmd[i], a[i], b[i], 32'd0, 32'd0, 2'b00, 2'd0, 1'b1, 5'd3, 1'b0, 1'b0);
         tick();
         vectors++;
         if (ALU_resOut !== exp[i]) begin
            miscompares++;
            $display("FAIL alu_dir[%0d] cmd=%b got %h want %h", i, cmd[i], ALU_resOut, exp[i]);
         end
      end
   endtask

   task automatic test_alu_random();
      logic [3:0]  cmd;
      logic [31:0] a, b, r;
      logic [1:0]  mem;
      logic        wb, fl;
      logic [4:0]  dest;
      for (int i = 0; i < 60; i++) begin
         cmd = 4'($urandom_range(0, 15));
         a = $urandom; b = $urandom; r = $urandom;
         if (i % 4 == 0) b = 32'($urandom_range(0, 40));
         mem = 2'($urandom_range(0, 3));
         wb = 1'($urandom_range(0, 1));
         fl = ($urandom_range(0, 3) == 0);
         dest = 5'($urandom_range(0, 31));
         drive(cmd, a, b, r, 32'd0, mem, 2'd0, wb, dest, fl, 1'b0);
         tick();
         vectors++;
         if (ALU_resOut !== alu_ref(cmd, a, b) || ST_valOut !== r || destOut !== dest ||
             WB_ENout !== (wb & ~fl) || MEM_SignalOut !== (fl ? 2'b00 : mem)) begin
            miscompares++;
            $display("FAIL alu_rand[%0d] cmd=%b a=%h b=%h got res=%h st=%h dest=%0d wb=%b mem=%b want res=%h st=%h dest=%0d wb=%b mem=%b",
                     i, cmd, a, b, ALU_resOut, ST_valOut, destOut, WB_ENout, MEM_SignalOut,
                     alu_ref(cmd, a, b), r, dest, wb & ~fl, fl ? 2'b00 : mem);
         end
      end
   endtask

   task automatic test_branch();
      logic [31:0] a, b, r, pc;
      logic [1:0]  bt;
      logic        fl, fz, exp_t;
      drive(4'd0, 32'd0, 32'd3, 32'd0, 32'h100, 2'b00, 2'd1, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (Br_taken !== 1'b1 || flushOut !== 1'b1 || Br_addr !== 32'h10C) begin
         miscompares++;
         $display("FAIL bez_taken got taken=%b flush=%b addr=%h want 1 1 0000010c", Br_taken, flushOut, Br_addr);
      end
      val1 = 32'd1;
      #1;
      vectors++;
      if (Br_taken !== 1'b0 || flushOut !== 1'b0) begin
         miscompares++;
         $display("FAIL bez_not got taken=%b flush=%b want 0 0", Br_taken, flushOut);
      end
      drive(4'd0, 32'd4, 32'd1, 32'd4, 32'h200, 2'b00, 2'd2, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (Br_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL bne_eq got taken=%b want 0", Br_taken);
      end
      reg2 = 32'd5;
      #1;
      vectors++;
      if (Br_taken !== 1'b1 || Br_addr !== 32'h204) begin
         miscompares++;
         $display("FAIL bne_ne got taken=%b addr=%h want 1 00000204", Br_taken, Br_addr);
      end
      drive(4'd0, 32'd7, 32'd2, 32'd0, 32'h300, 2'b11, 2'd3, 1'b1, 5'd6, 1'b1, 1'b0);
      #1;
      vectors++;
      if (Br_taken !== 1'b0 || flushOut !== 1'b0) begin
         miscompares++;
         $display("FAIL jmp_flushed got taken=%b flush=%b want 0 0", Br_taken, flushOut);
      end
      tick();
      vectors++;
      if (WB_ENout !== 1'b0 || MEM_SignalOut !== 2'b00) begin
         miscompares++;
         $display("FAIL jmp_bubble got wb=%b mem=%b want 0 00", WB_ENout, MEM_SignalOut);
      end
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         r = ($urandom_range(0, 3) == 0) ? a : $urandom;
         b = $urandom; pc = $urandom;
         bt = 2'($urandom_range(0, 3));
         fl = ($urandom_range(0, 3) == 0);
         fz = ($urandom_range(0, 3) == 0);
         drive(4'd0, a, b, r, pc, 2'b00, bt, 1'b0, 5'd0, fl, fz);
         #1;
         exp_t = br_ref(bt, a, r) & ~fl & ~fz;
         vectors++;
         if (Br_taken !== exp_t || flushOut !== exp_t || Br_addr !== pc + b * 4) begin
            miscompares++;
            $display("FAIL br_rand[%0d] bt=%b got taken=%b flush=%b addr=%h want %b %b %h",
                     i, bt, Br_taken, flushOut, Br_addr, exp_t, exp_t, pc + b * 4);
         end
      end
      freeze = 1'b0;
      tick();
   endtask

   task automatic test_freeze();
      drive(4'd0, 32'd1, 32'd2, 32'd11, 32'd0, 2'b00, 2'd0, 1'b1, 5'd7, 1'b0, 1'b0);
      tick();
      drive(4'd0, 32'h40, 32'd8, 32'd22, 32'd0, 2'b10, 2'd0, 1'b1, 5'd9, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if (ALU_resOut !== 32'd3 || ST_valOut !== 32'd11 || destOut !== 5'd7 ||
             MEM_SignalOut !== 2'b00 || WB_ENout !== 1'b1) begin
            miscompares++;
            $display("FAIL freeze_hold[%0d] got res=%h st=%h dest=%0d mem=%b wb=%b want 3 b 7 00 1",
                     i, ALU_resOut, ST_valOut, destOut, MEM_SignalOut, WB_ENout);
         end
      end
      freeze = 1'b0;
      tick();
      vectors++;
      if (ALU_resOut !== 32'h48 || MEM_SignalOut !== 2'b10 || destOut !== 5'd9 || ST_valOut !== 32'd22) begin
         miscompares++;
         $display("FAIL freeze_release got res=%h mem=%b dest=%0d st=%h want 48 10 9 16",
                  ALU_resOut, MEM_SignalOut, destOut, ST_valOut);
      end
   endtask

   task automatic test_async_reset();
      drive(4'd5, 32'hF0, 32'h0F, 32'h55, 32'd0, 2'b01, 2'd0, 1'b1, 5'd12, 1'b0, 1'b0);
      tick();
      drive(4'd0, 32'd1, 32'd1, 32'd1, 32'd0, 2'b10, 2'd3, 1'b1, 5'd13, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({ALU_resOut, ST_valOut, destOut, MEM_SignalOut, WB_ENout} !== 72'd0 ||
          Br_taken !== 1'b0 || flushOut !== 1'b0) begin
         miscompares++;
         $display("FAIL async_rst got res=%h st=%h dest=%0d mem=%b wb=%b taken=%b want all 0",
                  ALU_resOut, ST_valOut, destOut, MEM_SignalOut, WB_ENout, Br_taken);
      end
      tick();
      vectors++;
      if ({ALU_resOut, ST_valOut, destOut, MEM_SignalOut, WB_ENout} !== 72'd0) begin
         miscompares++;
         $display("FAIL rst_held got res=%h dest=%0d wb=%b want 0", ALU_resOut, destOut, WB_ENout);
      end
      #2;
      rst = 1'b0;
      drive(4'd0, 32'd10, 32'd20, 32'd0, 32'd0, 2'b00, 2'd0, 1'b1, 5'd4, 1'b0, 1'b0);
      tick();
      vectors++;
      if (ALU_resOut !== 32'd30 || destOut !== 5'd4 || WB_ENout !== 1'b1) begin
         miscompares++;
         $display("FAIL post_rst got res=%0d dest=%0d wb=%b want 30 4 1", ALU_resOut, destOut, WB_ENout);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e_res, e_st, a, b, r;
      logic [4:0]  e_dest, dest;
      logic [1:0]  e_mem, mem;
      logic        e_wb, wb, fl, fz;
      logic [3:0]  cmd;
      e_res = ALU_resOut; e_st = ST_valOut; e_dest = destOut; e_mem = MEM_SignalOut; e_wb = WB_ENout;
      e_res = 32'd30; e_st = 32'd0; e_dest = 5'd4; e_mem = 2'b00; e_wb = 1'b1;
      for (int i = 0; i < 80; i++) begin
         cmd = 4'($urandom_range(0, 15));
         a = $urandom; b = $urandom; r = $urandom;
         mem = 2'($urandom_range(0, 3));
         wb = 1'($urandom_range(0, 1));
         dest = 5'($urandom_range(0, 31));
         fl = ($urandom_range(0, 4) == 0);
         fz = ($urandom_range(0, 3) == 0);
         drive(cmd, a, b, r, 32'd0, mem, 2'd0, wb, dest, fl, fz);
         tick();
         if (!fz) begin
            e_res = alu_ref(cmd, a, b); e_st = r; e_dest = dest;
            e_mem = fl ? 2'b00 : mem; e_wb = wb & ~fl;
         end
         vectors++;
         if (ALU_resOut !== e_res || ST_valOut !== e_st || destOut !== e_dest ||
             MEM_SignalOut !== e_mem || WB_ENout !== e_wb) begin
            miscompares++;
            $display("FAIL b2b[%0d] fz=%b fl=%b got res=%h st=%h dest=%0d mem=%b wb=%b want res=%h st=%h dest=%0d mem=%b wb=%b",
                     i, fz, fl, ALU_resOut, ST_valOut, destOut, MEM_SignalOut, WB_ENout,
                     e_res, e_st, e_dest, e_mem, e_wb);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      test_reset();
      test_alu_directed();
      test_alu_random();
      test_branch();
      test_freeze();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
